// File: rtl/ni_input_unit_pkg.sv
// Packet constants and helpers shared by the NI receive path.
//   ROUTER_*        : router flit layout {info[35:32], addr[31:16], data[15:0]}
//   INFO_*          : packet class codes carried in the info field
//   TOT_FIFO_DEPTH  : upstream credit count at reset (= NI input FIFO depth)
//   pe_act_no()     : activation index carried in addr[11:6]
package ni_input_unit_pkg;
  localparam int ROUTER_WIDTH      = 36;
  localparam int ROUTER_ADDR_WIDTH = 16;
  localparam int ROUTER_INFO_WIDTH = 4;
  localparam int PE_DATA_BUS       = 16;
  localparam int PE_ACT_NO_BUS     = 6;
  localparam int PE_IDX_W          = 6;
  localparam int TOT_FIFO_DEPTH    = 4;

  typedef enum logic [ROUTER_INFO_WIDTH-1:0] {
    INFO_BROADCAST     = 4'd1,
    INFO_UV            = 4'd2,
    INFO_FIN_BROADCAST = 4'd3,
    INFO_FIN_COMP      = 4'd4,
    INFO_READ          = 4'd5
  } info_e;

  typedef struct packed {
    logic [ROUTER_INFO_WIDTH-1:0] info;
    logic [ROUTER_ADDR_WIDTH-1:0] addr;
    logic [PE_DATA_BUS-1:0]       data;
  } pkt_t;

  function automatic logic [PE_ACT_NO_BUS-1:0] pe_act_no(input logic [ROUTER_ADDR_WIDTH-1:0] addr);
    return addr[11:6];
  endfunction
endpackage

// File: rtl/ni_input_unit_if.sv
// Router/PE-facing bundle of the NI input unit.
//   slave  : the input unit (consumes packets, drives dispatch/credit/error outputs)
//   master : router + PE controller side
interface ni_input_unit_if import ni_input_unit_pkg::*; ();
  logic                         in_data_valid;
  logic [ROUTER_WIDTH-1:0]      in_data;
  logic                         upstream_credit;
  logic                         act_recv_en;
  logic [ROUTER_ADDR_WIDTH-1:0] act_recv_addr;
  logic [PE_DATA_BUS-1:0]       act_recv_data;
  logic                         act_recv_rdy;
  logic                         part_sum_recv_en;
  logic [ROUTER_ADDR_WIDTH-1:0] part_sum_recv_addr;
  logic [PE_DATA_BUS-1:0]       part_sum_recv_data;
  logic                         part_sum_recv_rdy;
  logic                         fin_broadcast;
  logic                         fin_comp_recv;
  logic [PE_IDX_W-1:0]          fin_comp_pe_idx;
  logic                         ni_read_rqst;
  logic [PE_ACT_NO_BUS-1:0]     ni_read_addr;
  logic                         read_rqst_read_en;
  logic                         err_overflow;
  logic                         err_bad_pkt;

  modport slave (
    input  in_data_valid, in_data, act_recv_rdy, part_sum_recv_rdy, read_rqst_read_en,
    output upstream_credit, act_recv_en, act_recv_addr, act_recv_data,
           part_sum_recv_en, part_sum_recv_addr, part_sum_recv_data,
           fin_broadcast, fin_comp_recv, fin_comp_pe_idx,
           ni_read_rqst, ni_read_addr, err_overflow, err_bad_pkt
  );

  modport master (
    output in_data_valid, in_data, act_recv_rdy, part_sum_recv_rdy, read_rqst_read_en,
    input  upstream_credit, act_recv_en, act_recv_addr, act_recv_data,
           part_sum_recv_en, part_sum_recv_addr, part_sum_recv_data,
           fin_broadcast, fin_comp_recv, fin_comp_pe_idx,
           ni_read_rqst, ni_read_addr, err_overflow, err_bad_pkt
  );
endinterface

// File: rtl/ni_input_fifo.sv
// Synchronous circular FIFO. Caller guarantees push only when not full (or
// popping) and pop only when not empty.
//   clk, rst      : clock, sync active-high reset
//   push/wdata    : write at tail
//   pop           : advance head
//   head          : current head entry (registered storage, read combinationally)
//   count/full/empty : occupancy
module ni_input_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // storage carries no reset: stale entries are invisible once count is 0
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/ni_input_unit.sv
// NI receive side: buffers router packets and dispatches the head to the PE.
//   clk, rst : clock, sync active-high reset
//   PE_IDX   : this PE's index (READ packets must target it)
//   bus      : router input, credit return, PE dispatch handshakes, error flags
// Valid outputs are decoded from the FIFO head and held until the matching
// pop; FIN_* and bad packets pop unconditionally. One credit pulse follows
// every pop.
module ni_input_unit import ni_input_unit_pkg::*; #(
  parameter int FIFO_DEPTH = TOT_FIFO_DEPTH,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PE_IDX_W-1:0] PE_IDX,
  ni_input_unit_if.slave      bus
);
  logic [ROUTER_WIDTH-1:0] head_raw;
  logic [CNT_WIDTH-1:0]    fifo_count;
  logic                    fifo_full, fifo_empty;
  logic                    push_ok, pop;
  pkt_t                    head;

  ni_input_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ROUTER_WIDTH), .CNT_W(CNT_WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata (bus.in_data),
    .pop   (pop),
    .head  (head_raw),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = pkt_t'(head_raw);

  logic nonempty, rd_match;
  logic is_bc, is_uv, is_rd_any, is_rd, is_fb, is_fc, is_bad;

  assign nonempty = !fifo_empty;
  assign rd_match = (head.addr[5:0] == PE_IDX);

  always_comb begin
    is_bc     = 1'b0;
    is_uv     = 1'b0;
    is_rd_any = 1'b0;
    is_fb     = 1'b0;
    is_fc     = 1'b0;
    is_bad    = 1'b0;
    if (nonempty) begin
      case (head.info)
        INFO_BROADCAST:     is_bc     = 1'b1;
        INFO_UV:            is_uv     = 1'b1;
        INFO_READ:          is_rd_any = 1'b1;
        INFO_FIN_BROADCAST: is_fb     = 1'b1;
        INFO_FIN_COMP:      is_fc     = 1'b1;
        default:            is_bad    = 1'b1;
      endcase
      // a READ aimed at another PE is misrouted and treated as garbage
      if (is_rd_any && !rd_match) is_bad = 1'b1;
    end
  end

  assign is_rd = is_rd_any && rd_match;

  assign pop = (is_bc && bus.act_recv_rdy) ||
               (is_uv && bus.part_sum_recv_rdy) ||
               (is_rd && bus.read_rqst_read_en) ||
               is_fb || is_fc || is_bad;

  // a full FIFO can still accept when the head leaves in the same cycle
  assign push_ok = bus.in_data_valid && (!fifo_full || pop);

  // fields are gated so idle outputs read as zero
  assign bus.act_recv_en        = is_bc;
  assign bus.act_recv_addr      = is_bc ? head.addr : '0;
  assign bus.act_recv_data      = is_bc ? head.data : '0;
  assign bus.part_sum_recv_en   = is_uv;
  assign bus.part_sum_recv_addr = is_uv ? head.addr : '0;
  assign bus.part_sum_recv_data = is_uv ? head.data : '0;
  assign bus.ni_read_rqst       = is_rd;
  assign bus.ni_read_addr       = is_rd ? pe_act_no(head.addr) : '0;

  logic                credit_q, fin_b_q, fin_c_q, err_ovf_q, err_bad_q;
  logic [PE_IDX_W-1:0] fin_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q  <= 1'b0;
      fin_b_q   <= 1'b0;
      fin_c_q   <= 1'b0;
      fin_idx_q <= '0;
      err_ovf_q <= 1'b0;
      err_bad_q <= 1'b0;
    end else begin
      credit_q <= pop;
      fin_b_q  <= is_fb;
      fin_c_q  <= is_fc;
      if (is_fc) fin_idx_q <= head.data[PE_IDX_W-1:0];
      if (bus.in_data_valid && !pop && fifo_count == CNT_WIDTH'(FIFO_DEPTH)) err_ovf_q <= 1'b1;
      if (is_bad) err_bad_q <= 1'b1;
    end
  end

  assign bus.upstream_credit = credit_q;
  assign bus.fin_broadcast   = fin_b_q;
  assign bus.fin_comp_recv   = fin_c_q;
  assign bus.fin_comp_pe_idx = fin_idx_q;
  assign bus.err_overflow    = err_ovf_q;
  assign bus.err_bad_pkt     = err_bad_q;
endmodule

// File: tb/tb_ni_input_unit.sv
// Bench for ni_input_unit: directed scenarios then randomized traffic, every
// cycle compared with a queue-based reference of the packet rules.
module tb_ni_input_unit;
  import ni_input_unit_pkg::*;

  localparam int DEPTH = TOT_FIFO_DEPTH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] pe_idx = 6'd5;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ni_input_unit_if bus();

  ni_input_unit dut (
    .clk    (clk),
    .rst    (rst),
    .PE_IDX (pe_idx),
    .bus    (bus)
  );

  // reference state
  logic [35:0] q[$];
  logic        m_credit, m_finb, m_finc, m_ovf, m_bad;
  logic [5:0]  m_idx;

  function automatic logic [35:0] mk(input logic [3:0] info, input logic [15:0] addr, input logic [15:0] data);
    return {info, addr, data};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_credit = 0; m_finb = 0; m_finc = 0; m_ovf = 0; m_bad = 0; m_idx = '0;
  endtask

  // One clock: compare at negedge, advance the reference at posedge.
  task automatic cyc();
    logic [35:0] h;
    logic [3:0]  info;
    logic [15:0] addr, data;
    logic        ne, e_bc, e_uv, e_rd, pop, fb, fc;
    @(negedge clk);
    ne   = (q.size() > 0);
    h    = ne ? q[0] : 36'd0;
    info = h[35:32]; addr = h[31:16]; data = h[15:0];
    e_bc = ne && info == INFO_BROADCAST;
    e_uv = ne && info == INFO_UV;
    e_rd = ne && info == INFO_READ && addr[5:0] == pe_idx;
    chk("act_recv", {bus.act_recv_en, bus.act_recv_addr, bus.act_recv_data},
        {e_bc, e_bc ? addr : 16'd0, e_bc ? data : 16'd0});
    chk("part_sum_recv", {bus.part_sum_recv_en, bus.part_sum_recv_addr, bus.part_sum_recv_data},
        {e_uv, e_uv ? addr : 16'd0, e_uv ? data : 16'd0});
    chk("ni_read", {bus.ni_read_rqst, bus.ni_read_addr}, {e_rd, e_rd ? addr[11:6] : 6'd0});
    chk("credit", 64'(bus.upstream_credit), 64'(m_credit));
    chk("fin", {bus.fin_broadcast, bus.fin_comp_recv, bus.fin_comp_pe_idx}, {m_finb, m_finc, m_idx});
    chk("err", {bus.err_overflow, bus.err_bad_pkt}, {m_ovf, m_bad});
    @(posedge clk);
    if (rst) model_reset();
    else begin
      pop = 0; fb = 0; fc = 0;
      if (ne) begin
        case (info)
          INFO_BROADCAST:     pop = bus.act_recv_rdy;
          INFO_UV:            pop = bus.part_sum_recv_rdy;
          INFO_READ:          if (addr[5:0] == pe_idx) pop = bus.read_rqst_read_en;
                              else begin pop = 1; m_bad = 1; end
          INFO_FIN_BROADCAST: begin pop = 1; fb = 1; end
          INFO_FIN_COMP:      begin pop = 1; fc = 1; m_idx = data[5:0]; end
          default:            begin pop = 1; m_bad = 1; end
        endcase
      end
      if (pop) void'(q.pop_front());
      if (bus.in_data_valid) begin
        if (q.size() < DEPTH) q.push_back(bus.in_data);
        else m_ovf = 1;
      end
      m_credit = pop; m_finb = fb; m_finc = fc;
    end
    #1;
  endtask

  task automatic push(input logic [35:0] p);
    bus.in_data_valid = 1'b1;
    bus.in_data       = p;
    cyc();
    bus.in_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    logic [3:0]  ri;
    logic [15:0] ra;
    bus.in_data_valid     = 1'b0;
    bus.in_data           = '0;
    bus.act_recv_rdy      = 1'b0;
    bus.part_sum_recv_rdy = 1'b0;
    bus.read_rqst_read_en = 1'b0;
    model_reset();
    @(posedge clk); #1;
    idle(2);                        // reset state with rst held
    rst = 1'b0;

    // 1: four ordered broadcasts with rdy high
    bus.act_recv_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) push(mk(INFO_BROADCAST, 16'(i), 16'h00A0 + 16'(i - 1)));
    idle(3);

    // 2: overflow on the fifth push, then drain
    bus.act_recv_rdy = 1'b0;
    for (int i = 0; i < 5; i++) push(mk(INFO_BROADCAST, 16'h0010 + 16'(i), 16'h00B0 + 16'(i)));
    idle(2);
    bus.act_recv_rdy = 1'b1;
    idle(6);

    // 3: READ held until the output unit takes it
    push(mk(INFO_READ, {4'b0, 6'd13, 6'd5}, 16'h1234));
    idle(3);
    bus.read_rqst_read_en = 1'b1;
    cyc();
    bus.read_rqst_read_en = 1'b0;
    idle(2);

    // 4: FIN_COMP pulse, then a misrouted READ
    push(mk(INFO_FIN_COMP, 16'h0000, 16'h0015));
    idle(3);
    push(mk(INFO_READ, {4'b0, 6'd2, 6'd6}, 16'h0000));
    idle(3);

    // 5: full UV FIFO with simultaneous push and pop
    bus.part_sum_recv_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(INFO_UV, 16'h0100 + 16'(i), 16'h0C00 + 16'(i)));
    bus.part_sum_recv_rdy = 1'b1;
    push(mk(INFO_UV, 16'h0199, 16'h0C99));
    bus.part_sum_recv_rdy = 1'b0;
    cyc();
    bus.part_sum_recv_rdy = 1'b1;
    idle(6);

    // 6: reset with packets queued, then a fresh push
    bus.part_sum_recv_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push(mk(INFO_UV, 16'h0200 + 16'(i), 16'h0D00 + 16'(i)));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    push(mk(INFO_BROADCAST, 16'h0300, 16'h0E00));
    idle(3);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: ri = INFO_BROADCAST;
        3, 4:    ri = INFO_UV;
        5, 6:    ri = INFO_READ;
        7:       ri = INFO_FIN_BROADCAST;
        8:       ri = INFO_FIN_COMP;
        default: ri = 4'($urandom_range(6, 15));
      endcase
      ra = 16'($urandom);
      if (ri == INFO_READ && $urandom_range(0, 3) != 0) ra[5:0] = pe_idx;
      bus.in_data_valid     = ($urandom_range(0, 2) != 0);
      bus.in_data           = mk(ri, ra, 16'($urandom));
      bus.act_recv_rdy      = ($urandom_range(0, 2) != 0);
      bus.part_sum_recv_rdy = ($urandom_range(0, 2) != 0);
      bus.read_rqst_read_en = ($urandom_range(0, 2) != 0);
      rst                   = ($urandom_range(0, 127) == 0);
      cyc();
    end
    bus.in_data_valid = 1'b0;
    rst = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
